// File: rtl/sync_bus_qualifier.sv
// ---------------------------------------------------------------------------
// sync_bus_qualifier
//
// Purpose:
//   Sits after a bit-array synchronizer in the destination clock domain.
//   Because individual bits of the synchronized bus can settle on different
//   cycles, a single raw sample may be incoherent. This block only commits a
//   bus value once it has been seen unchanged for STABLE_CYCLES consecutive
//   samples, then reports the committed value together with per-bit rise and
//   fall event masks that status/control logic can consume directly.
//
// Parameters:
//   BUS_WIDTH      width of the synchronized bus
//   STABLE_CYCLES  consecutive matching samples required to commit (>= 1)
//
// Ports:
//   clk           destination-domain clock
//   rst           synchronous, active-high reset
//   data_in       synchronizer output, already in the clk domain
//   data_out      last committed (qualified) value
//   data_valid    high from the first commit until reset
//   stable        high while the input is qualified and unchanged
//   update_pulse  one-cycle strobe on a commit that changes data_out, or on
//                 the very first commit after reset
//   rise_mask     bits that went 0->1 at this commit, zero otherwise
//   fall_mask     bits that went 1->0 at this commit, zero otherwise
// ---------------------------------------------------------------------------
module sync_bus_qualifier #(
    parameter int BUS_WIDTH     = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] data_in,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 stable,
    output logic                 update_pulse,
    output logic [BUS_WIDTH-1:0] rise_mask,
    output logic [BUS_WIDTH-1:0] fall_mask
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // Count value at which the next matching sample completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_STABLE = 1'b1
    } state_t;

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_cand;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_match;
    logic                 w_changed;

    // r_cand holds the previous raw sample, so a match means the bus has
    // not moved since the last edge.
    assign w_match   = (data_in == r_cand);

    // A commit is only announced if it is the first one since reset or if it
    // actually moves data_out; a transient that returns to the committed
    // value re-qualifies silently.
    assign w_changed = !data_valid || (data_in != data_out);

    // Qualification FSM with all outputs registered. The strobe and masks
    // default to zero every edge so they can never stay high two cycles in a
    // row; only the commit branch sets them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SETTLE;
            r_cand       <= '0;
            r_cnt        <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            stable       <= 1'b0;
            update_pulse <= 1'b0;
            rise_mask    <= '0;
            fall_mask    <= '0;
        end else begin
            r_cand       <= data_in;
            update_pulse <= 1'b0;
            rise_mask    <= '0;
            fall_mask    <= '0;

            case (r_state)
                ST_SETTLE: begin
                    if (!w_match) begin
                        r_cnt <= '0;
                    end else if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // Qualified: commit the value in a single edge.
                        r_cnt      <= '0;
                        r_state    <= ST_STABLE;
                        data_out   <= data_in;
                        data_valid <= 1'b1;
                        stable     <= 1'b1;
                        if (w_changed) begin
                            update_pulse <= 1'b1;
                            rise_mask    <= data_in & ~data_out;
                            fall_mask    <= ~data_in & data_out;
                        end
                    end
                end

                ST_STABLE: begin
                    // Any movement drops stable immediately and restarts
                    // qualification; data_out keeps the last committed value.
                    if (!w_match) begin
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                        stable  <= 1'b0;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_SETTLE;
                    stable  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_bus_qualifier.sv
// ---------------------------------------------------------------------------
// tb_sync_bus_qualifier
//
// Drives two instances of sync_bus_qualifier (STABLE_CYCLES = 4 and 1) from
// the same bus and reset. Expected outputs come from a run-length model: a
// value commits on the edge where it has been seen for STABLE_CYCLES+1
// consecutive samples (the reset state counts as one sample of zero), and
// stable is high whenever the current run is at least that long.
// ---------------------------------------------------------------------------
module tb_sync_bus_qualifier;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] dataIn = '0;

    logic [W-1:0] outA, riseA, fallA;
    logic         validA, stableA, pulseA;
    logic [W-1:0] outB, riseB, fallB;
    logic         validB, stableB, pulseB;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state, index 0 = N4 instance, index 1 = N1 instance.
    int           mStableN [2] = '{4, 1};
    int           mRun     [2];
    logic [W-1:0] mPrev    [2];
    logic [W-1:0] mOut     [2];
    logic [W-1:0] mRise    [2];
    logic [W-1:0] mFall    [2];
    logic         mValid   [2];
    logic         mStable  [2];
    logic         mPulse   [2];

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    sync_bus_qualifier #(.BUS_WIDTH(W), .STABLE_CYCLES(4)) dutA (
        .clk(clk), .rst(rst), .data_in(dataIn),
        .data_out(outA), .data_valid(validA), .stable(stableA),
        .update_pulse(pulseA), .rise_mask(riseA), .fall_mask(fallA)
    );

    sync_bus_qualifier #(.BUS_WIDTH(W), .STABLE_CYCLES(1)) dutB (
        .clk(clk), .rst(rst), .data_in(dataIn),
        .data_out(outB), .data_valid(validB), .stable(stableB),
        .update_pulse(pulseB), .rise_mask(riseB), .fall_mask(fallB)
    );

    // Advance the run-length model of instance k by one clock edge.
    task automatic modelStep(input int k, input logic r, input logic [W-1:0] x);
        if (r) begin
            mRun[k]    = 1;
            mPrev[k]   = '0;
            mOut[k]    = '0;
            mValid[k]  = 1'b0;
            mStable[k] = 1'b0;
            mPulse[k]  = 1'b0;
            mRise[k]   = '0;
            mFall[k]   = '0;
        end else begin
            if (x == mPrev[k]) mRun[k] = (mRun[k] < 1000) ? mRun[k] + 1 : 1000;
            else               mRun[k] = 1;
            mPrev[k]  = x;
            mPulse[k] = 1'b0;
            mRise[k]  = '0;
            mFall[k]  = '0;
            if (mRun[k] == mStableN[k] + 1) begin
                if (!mValid[k] || x != mOut[k]) begin
                    mPulse[k] = 1'b1;
                    mRise[k]  = x & ~mOut[k];
                    mFall[k]  = ~x & mOut[k];
                end
                mOut[k]   = x;
                mValid[k] = 1'b1;
            end
            mStable[k] = (mRun[k] >= mStableN[k] + 1);
        end
    endtask

    task automatic checkOne(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output of both instances with the model.
    task automatic checkOutput(input string tag);
        checkOne({tag, " A.data_out"},     outA,             mOut[0]);
        checkOne({tag, " A.data_valid"},   {1'b0, validA},   {1'b0, mValid[0]});
        checkOne({tag, " A.stable"},       {1'b0, stableA},  {1'b0, mStable[0]});
        checkOne({tag, " A.update_pulse"}, {1'b0, pulseA},   {1'b0, mPulse[0]});
        checkOne({tag, " A.rise_mask"},    riseA,            mRise[0]);
        checkOne({tag, " A.fall_mask"},    fallA,            mFall[0]);
        checkOne({tag, " B.data_out"},     outB,             mOut[1]);
        checkOne({tag, " B.data_valid"},   {1'b0, validB},   {1'b0, mValid[1]});
        checkOne({tag, " B.stable"},       {1'b0, stableB},  {1'b0, mStable[1]});
        checkOne({tag, " B.update_pulse"}, {1'b0, pulseB},   {1'b0, mPulse[1]});
        checkOne({tag, " B.rise_mask"},    riseB,            mRise[1]);
        checkOne({tag, " B.fall_mask"},    fallB,            mFall[1]);
    endtask

    // Drive one cycle of stimulus, step the model on the edge, check #1 later.
    task automatic applyStimulus(input string tag, input logic r, input logic [W-1:0] x);
        rst    = r;
        dataIn = x;
        @(posedge clk);
        modelStep(0, r, x);
        modelStep(1, r, x);
        #1;
        checkOutput(tag);
    endtask

    int holdLen;
    logic [W-1:0] rv;

    initial begin
        $display("[TB] start");
        #2;

        // Reset state.
        applyStimulus("reset", 1'b1, 2'b00);
        applyStimulus("reset", 1'b1, 2'b00);
        checkOne("reset A.data_out", outA, 2'b00);

        // Input held at 0 after reset: first-commit strobe with zero masks.
        for (int i = 0; i < 3; i++) applyStimulus("hold00", 1'b0, 2'b00);
        checkOne("hold00 A.valid_before_commit", {1'b0, validA}, 2'b00);
        applyStimulus("hold00", 1'b0, 2'b00);
        checkOne("first commit A.pulse", {1'b0, pulseA}, 2'b01);
        checkOne("first commit A.valid", {1'b0, validA}, 2'b01);
        checkOne("first commit A.rise",  riseA, 2'b00);
        applyStimulus("hold00", 1'b0, 2'b00);
        checkOne("after commit A.pulse", {1'b0, pulseA}, 2'b00);

        // 00 -> 11: commit exactly four edges after the first sample.
        for (int i = 0; i < 4; i++) applyStimulus("step11", 1'b0, 2'b11);
        checkOne("step11 A.data_out_early", outA, 2'b00);
        applyStimulus("step11", 1'b0, 2'b11);
        checkOne("step11 A.data_out", outA, 2'b11);
        checkOne("step11 A.rise",     riseA, 2'b11);
        checkOne("step11 A.fall",     fallA, 2'b00);
        applyStimulus("step11", 1'b0, 2'b11);

        // One-cycle glitch to 10 that returns to the committed value.
        applyStimulus("glitch", 1'b0, 2'b10);
        checkOne("glitch A.stable", {1'b0, stableA}, 2'b00);
        for (int i = 0; i < 5; i++) applyStimulus("glitch", 1'b0, 2'b11);
        checkOne("glitch A.stable_back", {1'b0, stableA}, 2'b01);
        checkOne("glitch A.no_pulse",    {1'b0, pulseA},  2'b00);
        checkOne("glitch A.data_out",    outA,            2'b11);

        // Skewed transition 00 -> 01 -> 11 never commits the 01 midpoint.
        for (int i = 0; i < 6; i++) applyStimulus("skew00", 1'b0, 2'b00);
        applyStimulus("skew01", 1'b0, 2'b01);
        applyStimulus("skew01", 1'b0, 2'b01);
        for (int i = 0; i < 5; i++) applyStimulus("skew11", 1'b0, 2'b11);
        checkOne("skew A.rise", riseA, 2'b11);

        // Reset while a change to 10 is pending.
        for (int i = 0; i < 3; i++) applyStimulus("pend10", 1'b0, 2'b10);
        applyStimulus("midreset", 1'b1, 2'b10);
        checkOne("midreset A.data_out", outA, 2'b00);
        checkOne("midreset A.pulse", {1'b0, pulseA}, 2'b00);

        // N=1 back-to-back changes.
        for (int i = 0; i < 3; i++) applyStimulus("n1seq", 1'b0, 2'b00);
        applyStimulus("n1seq", 1'b0, 2'b01);
        applyStimulus("n1seq", 1'b0, 2'b01);
        checkOne("n1 B.data_out", outB, 2'b01);
        applyStimulus("n1seq", 1'b0, 2'b10);
        applyStimulus("n1seq", 1'b0, 2'b11);
        applyStimulus("n1seq", 1'b0, 2'b11);

        // Randomized runs of varying length with occasional reset.
        for (int j = 0; j < 250; j++) begin
            rv      = W'($urandom_range(0, 3));
            holdLen = $urandom_range(1, 7);
            for (int i = 0; i < holdLen; i++) begin
                applyStimulus("random", ($urandom_range(0, 60) == 0), rv);
            end
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
